// File: rtl/uart_tx_fifo_pkg.sv
// Shared peripheral definitions for the UART transmit FIFO: default depth
// and the issue-FSM state encoding.
package uart_tx_fifo_pkg;

  localparam int unsigned DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRAIN = 2'd2
  } issue_state_e;

endpackage : uart_tx_fifo_pkg

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Circular byte buffer with wrapping read/write pointers, occupancy counter
// and a sticky overflow flag for writes dropped while full.
module tx_byte_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          do_pop;

  // Flush outranks both queue operations; a write seen while full is dropped
  // even if a pop frees a slot on the same edge.
  assign push   = wr_en && !full && !flush;
  assign do_pop = pop && !empty && !flush;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign level = count;
  assign head  = mem[rd_ptr];

  // NOTE: the data array has no reset; stale bytes are unreachable because
  // the pointers and count are cleared, and leaving it out keeps plain flops.
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule : tx_byte_fifo

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: byte queue feeding a downstream transmitter through a
// three-state issue FSM (IDLE -> GUARD -> DRAIN) with a registered strobe/byte.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  input  logic                     tx_busy,
  output logic                     tx_en,
  output logic [7:0]               tx_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  issue_state_e state;
  issue_state_e next_state;
  logic [7:0]   head;
  logic         pop;

  tx_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  // Issue decision is taken in IDLE; strobe and byte are registered together
  // so the transmitter sees them aligned in the cycle after the pop.
  assign pop = (state == ST_IDLE) && !empty && !tx_busy && !flush;

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (pop) next_state = ST_GUARD;
      ST_GUARD: next_state = ST_DRAIN;
      ST_DRAIN: if (!tx_busy) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      state <= next_state;
      tx_en <= pop;
      if (pop) begin
        tx_data <= head;
      end
    end
  end

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus a randomized
// phase, all compared every cycle against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       tx_busy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       overflow;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .tx_busy  (tx_busy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: byte queue, sticky overflow, issue phase
  // (0 waiting to issue, 1 guard cycle, 2 waiting for transmitter idle).
  byte unsigned q[$];
  bit           m_ovf;
  bit           m_en;
  logic [7:0]   m_data;
  int           m_phase;

  // Model transmitter: busy for 'hold' cycles after each strobe.
  bit use_xmit = 1'b0;
  int tx_cnt   = 0;
  int hold     = 10;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    bit can_pop;
    bit was_full;
    if (!rstn) begin
      q.delete();
      m_ovf   = 1'b0;
      m_en    = 1'b0;
      m_data  = 8'h00;
      m_phase = 0;
      return;
    end
    can_pop  = (m_phase == 0) && (q.size() != 0) && !tx_busy && !flush;
    was_full = (q.size() == DEPTH);
    case (m_phase)
      0:       m_phase = can_pop ? 1 : 0;
      1:       m_phase = 2;
      default: m_phase = tx_busy ? 2 : 0;
    endcase
    m_en = can_pop;
    if (can_pop) m_data = q.pop_front();
    if (flush) begin
      q.delete();
      m_ovf = 1'b0;
    end else if (wr_en) begin
      if (was_full) m_ovf = 1'b1;
      else          q.push_back(wr_data);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("tx_en",    32'(tx_en),    32'(m_en));
    check("tx_data",  32'(tx_data),  32'(m_data));
    check("level",    32'(level),    32'(q.size()));
    check("full",     32'(full),     32'(q.size() == DEPTH));
    check("empty",    32'(empty),    32'(q.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (m_en)            tx_cnt = hold;
    else if (tx_cnt > 0) tx_cnt--;
    if (use_xmit) tx_busy = (tx_cnt > 0);
  endtask

  task automatic write(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    byte unsigned got[$];
    int           last_en;
    int           en_count;
    logic [7:0]   held;

    rstn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; tx_busy = 1'b0;
    tick();
    tick();
    check("rst_level", 32'(level), 0);
    check("rst_empty", 32'(empty), 1);
    rstn = 1'b1;
    tick();

    // Single byte into an empty FIFO with an idle transmitter.
    write(8'h41);
    check("lat_no_en_yet", 32'(tx_en), 0);
    tick();
    check("lat_tx_en",   32'(tx_en),   1);
    check("lat_tx_data", 32'(tx_data), 32'h41);
    check("lat_level",   32'(level),   0);
    check("lat_empty",   32'(empty),   1);
    repeat (3) tick();

    // Fill while the transmitter is busy, then overrun by one.
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) write(8'(i));
    check("fill_full",  32'(full),  1);
    check("fill_level", 32'(level), 8);
    write(8'hEE);
    check("ovf_set",   32'(overflow), 1);
    check("ovf_level", 32'(level),    8);

    // Drain through the model transmitter; check order and issue spacing.
    use_xmit = 1'b1;
    hold     = 10;
    tx_busy  = 1'b0;
    last_en  = -100;
    for (int c = 0; c < 150; c++) begin
      tick();
      if (tx_en === 1'b1) begin
        got.push_back(tx_data);
        if (last_en >= 0) check("tx_gap_ok", 32'(c - last_en >= hold + 2), 1);
        last_en = c;
      end
    end
    check("drain_count", 32'(got.size()), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check("drain_order", 32'(got[i]), 32'(i));
    check("drain_empty", 32'(empty), 1);

    // Flush with five queued and one in flight.
    do_flush();
    for (int i = 0; i < 6; i++) write(8'hA0 + 8'(i));
    check("pre_flush_level", 32'(level),   5);
    check("inflight_data",   32'(tx_data), 32'hA0);
    do_flush();
    check("flush_level", 32'(level),    0);
    check("flush_ovf",   32'(overflow), 0);
    check("flush_data",  32'(tx_data),  32'hA0);
    en_count = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (tx_en === 1'b1) en_count++;
    end
    check("flush_no_tx_en", 32'(en_count), 0);
    check("flush_data_hold", 32'(tx_data), 32'hA0);

    // Push and pop on the same edge: full case, then partially filled case.
    use_xmit = 1'b0;
    tx_busy  = 1'b0;
    do_flush();
    repeat (3) tick();
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) write(8'($urandom));
    check("pp_full_level", 32'(level), 8);
    tx_busy = 1'b0;
    write(8'h5A);
    check("pp_full_pop",   32'(tx_en),    1);
    check("pp_full_level2", 32'(level),   7);
    check("pp_full_ovf",   32'(overflow), 1);
    tx_busy = 1'b1;
    do_flush();
    tx_busy = 1'b0;
    repeat (3) tick();
    tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) write(8'($urandom));
    tx_busy = 1'b0;
    write(8'h77);
    check("pp_mid_pop",   32'(tx_en),    1);
    check("pp_mid_level", 32'(level),    3);
    check("pp_mid_ovf",   32'(overflow), 0);

    // Reset during DRAIN with four queued.
    do_flush();
    repeat (3) tick();
    write(8'h10);
    write(8'h11);
    tx_busy = 1'b1;
    write(8'h12);
    write(8'h13);
    write(8'h14);
    check("pre_rst_level", 32'(level), 4);
    rstn = 1'b0;
    tick();
    check("rst_mid_level", 32'(level), 0);
    check("rst_mid_tx_en", 32'(tx_en), 0);
    check("rst_mid_data",  32'(tx_data), 0);
    rstn    = 1'b1;
    tx_busy = 1'b0;
    en_count = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (tx_en === 1'b1) en_count++;
    end
    check("rst_no_tx_en", 32'(en_count), 0);

    // Randomized traffic with occasional flush and reset.
    use_xmit = 1'b1;
    for (int c = 0; c < 400; c++) begin
      wr_en   = ($urandom % 2) == 0;
      wr_data = 8'($urandom);
      flush   = ($urandom % 40) == 0;
      rstn    = ($urandom % 150) != 0;
      hold    = int'($urandom_range(0, 4));
      tick();
    end
    wr_en = 1'b0; flush = 1'b0; rstn = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_tx_fifo

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 8, giving the number of byte entries; DEPTH SHALL be a power of two and at least 2.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port wr_en, input, 1 bit: CPU write strobe, one byte per cycle it is high.
REQ-005 Port wr_data, input, 8 bits: byte to enqueue.
REQ-006 Port flush, input, 1 bit: discard all queued bytes.
REQ-007 Port tx_busy, input, 1 bit: busy flag from the downstream UART transmitter.
REQ-008 Port tx_en, output, 1 bit: single-cycle start pulse to the transmitter.
REQ-009 Port tx_data, output, 8 bits: registered byte presented to the transmitter.
REQ-010 Port full, output, 1 bit: level == DEPTH.
REQ-011 Port empty, output, 1 bit: level == 0.
REQ-012 Port level, output, log2(DEPTH)+1 bits: current occupancy.
REQ-013 Port overflow, output, 1 bit: sticky flag for a dropped write.

Function
REQ-014 Storage SHALL be a circular buffer with log2(DEPTH)-bit read and write pointers that wrap from DEPTH-1 to 0, plus an occupancy counter.
REQ-015 A write with wr_en=1 and full=0 at the clock edge SHALL store wr_data at the write pointer and advance that pointer.
REQ-016 A write with full=1 SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-017 The issue FSM SHALL have three states: IDLE, GUARD and DRAIN.
REQ-018 In IDLE with empty=0 and tx_busy=0, the block SHALL pop the head entry into tx_data, pulse tx_en for exactly one cycle, and go to GUARD.
REQ-019 GUARD SHALL last one cycle, ignore tx_busy, and go to DRAIN.
REQ-020 DRAIN SHALL return to IDLE on the first cycle in which tx_busy=0.
REQ-021 Latency: a byte written into an empty FIFO while the FSM is in IDLE and tx_busy=0 SHALL produce tx_en on the next cycle.
REQ-022 tx_data SHALL hold its value from the tx_en cycle until the next pop.
REQ-023 A push and a pop in the same cycle SHALL leave level unchanged and advance both pointers.
REQ-024 flush SHALL zero both pointers, level and overflow.
REQ-025 flush SHALL NOT abort a byte already issued; the FSM SHALL continue, and tx_data SHALL be unchanged.
REQ-026 When flush and wr_en are high in the same cycle, flush SHALL win: the write is discarded and overflow is not set.
REQ-027 When flush is high in IDLE, no pop SHALL occur that cycle.
REQ-028 tx_en SHALL never be asserted outside IDLE, and never while empty=1.

Reset
REQ-029 While rstn=0 at a clock edge, the block SHALL clear the pointers and level, set state to IDLE, and drive tx_en=0, tx_data=8'h00, overflow=0, empty=1 and full=0.
REQ-030 Reset mid-transmission SHALL discard the FIFO contents and the FSM state without emitting tx_en.
REQ-031 The block SHALL sample nothing else while rstn=0.

Structure
REQ-032 The default DEPTH and the FSM state encoding SHALL live in the shared peripheral package.
REQ-033 Storage and pointer logic SHALL be one sub-module, tx_byte_fifo; the issue FSM SHALL stay in uart_tx_fifo.
REQ-034 The storage SHALL be flops with no reset on the data array.

Verification
REQ-035 Reset, then write 8'h41 with tx_busy=0 -> tx_en on the next cycle with tx_data=8'h41; level returns to 0; empty=1.
REQ-036 Write 8 bytes 8'h00..8'h07 back-to-back while tx_busy is held at 1 -> full=1, level=8; a 9th write sets overflow=1 and level stays 8.
REQ-037 Hold tx_busy at 1 for 10 cycles after each tx_en, with a model transmitter -> bytes emerge in order 8'h00..8'h07; tx_en is never closer than GUARD plus busy allows; pointers wrap correctly.
REQ-038 Assert flush while 5 bytes are queued and one is in flight -> level=0 and overflow=0; the in-flight tx_data is unchanged; no further tx_en occurs.
REQ-039 With level=8, wr_en and a pop in the same cycle -> the write is dropped, overflow=1, level=7; with level=3, the same event leaves level=3.
REQ-040 Assert rstn=0 during DRAIN with 4 bytes queued -> the next cycle shows level=0, tx_en=0, state IDLE; the bench releases tx_busy and observes no tx_en.
